// File: rtl/sys_pkg.sv
// sys_pkg: command bytes, operand addresses and the sequencer state encoding
// shared by sys_ctrl and its TX push helper.
package sys_pkg;

  localparam logic [7:0] CMD_RF_WR   = 8'hAA;
  localparam logic [7:0] CMD_RF_RD   = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;
  localparam logic [7:0] ERR_RSP     = 8'hEE;

  // Register-file slots that hold ALU operands A and B.
  localparam int OPA_ADDR = 0;
  localparam int OPB_ADDR = 1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR_ADDR,
    ST_WR_DATA,
    ST_RD_ADDR,
    ST_RD_WAIT,
    ST_TX_RD,
    ST_ALU_A,
    ST_ALU_B,
    ST_ALU_FUN,
    ST_ALU_WAIT,
    ST_TX_LSB,
    ST_TX_MSB,
    ST_TX_ERR
  } state_e;

  // States that own a byte destined for the TX FIFO.
  function automatic logic is_tx_state(input state_e s);
    return (s == ST_TX_RD) || (s == ST_TX_LSB) || (s == ST_TX_MSB) || (s == ST_TX_ERR);
  endfunction

endpackage

// File: rtl/sys_ctrl_tx_push.sv
// sys_ctrl_tx_push: registered byte push toward the TX FIFO. A request is
// honoured only when the FIFO has room; otherwise the strobe stays low and the
// last pushed byte stays on the data lines until the caller tries again.
module sys_ctrl_tx_push #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  fifo_full_i,
  output logic                  tx_d_vld_o,
  output logic [DATA_WIDTH-1:0] tx_p_data_o
);

  logic                  push;
  logic                  tx_vld_q;
  logic [DATA_WIDTH-1:0] tx_data_q;

  assign push = req_i && !fifo_full_i;

  // Register the one-cycle strobe and latch the byte only when it is pushed.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with <= so every register samples pre-edge values;
    // a blocking = here would let later statements see the new value early.
    if (rst) begin
      tx_vld_q  <= 1'b0;
      tx_data_q <= '0;
    end else begin
      tx_vld_q <= push;
      if (push) tx_data_q <= data_i;
    end
  end

  assign tx_d_vld_o  = tx_vld_q;
  assign tx_p_data_o = tx_data_q;

endmodule

// File: rtl/sys_ctrl.sv
// sys_ctrl: byte-command sequencer between the UART RX stream and the
// register file / ALU / TX FIFO. All outputs are registered.
// Optional feature: define SYS_CTRL_ERR_RSP_EN to answer unknown command bytes
// with a single 0xEE pushed to the TX FIFO.
module sys_ctrl
  import sys_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FUN_WIDTH  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   rx_p_data,
  input  logic                    rx_d_vld,
  input  logic [DATA_WIDTH-1:0]   rf_rd_data,
  input  logic                    rf_rd_data_vld,
  input  logic [2*DATA_WIDTH-1:0] alu_out,
  input  logic                    alu_out_vld,
  input  logic                    fifo_full,
  output logic                    rf_wr_en,
  output logic                    rf_rd_en,
  output logic [ADDR_WIDTH-1:0]   rf_addr,
  output logic [DATA_WIDTH-1:0]   rf_wr_data,
  output logic                    alu_en,
  output logic [FUN_WIDTH-1:0]    alu_fun,
  output logic                    clk_g_en,
  output logic [DATA_WIDTH-1:0]   tx_p_data,
  output logic                    tx_d_vld
);

  state_e                  state_q, state_d;
  logic                    rf_wr_en_q, rf_wr_en_d;
  logic                    rf_rd_en_q, rf_rd_en_d;
  logic [ADDR_WIDTH-1:0]   rf_addr_q, rf_addr_d;
  logic [DATA_WIDTH-1:0]   rf_wr_data_q, rf_wr_data_d;
  logic                    alu_en_q, alu_en_d;
  logic [FUN_WIDTH-1:0]    alu_fun_q, alu_fun_d;
  logic                    clk_g_en_q, clk_g_en_d;
  logic [2*DATA_WIDTH-1:0] res_q, res_d;
  logic                    push_req;
  logic [DATA_WIDTH-1:0]   push_byte;

  // Next state, next output values and the TX push request.
  always_comb begin
    // NOTE: every variable gets a default before the case, so no path can
    // leave one unassigned and infer a latch.
    state_d      = state_q;
    rf_wr_en_d   = 1'b0;
    rf_rd_en_d   = 1'b0;
    rf_addr_d    = rf_addr_q;
    rf_wr_data_d = rf_wr_data_q;
    alu_fun_d    = alu_fun_q;
    res_d        = res_q;

    case (state_q)
      ST_IDLE: if (rx_d_vld) begin
        case (rx_p_data)
          CMD_RF_WR:   state_d = ST_WR_ADDR;
          CMD_RF_RD:   state_d = ST_RD_ADDR;
          CMD_ALU_OP:  state_d = ST_ALU_A;
          CMD_ALU_NOP: state_d = ST_ALU_FUN;
`ifdef SYS_CTRL_ERR_RSP_EN
          default:     state_d = ST_TX_ERR;
`else
          default:     state_d = ST_IDLE;
`endif
        endcase
      end
      ST_WR_ADDR: if (rx_d_vld) begin
        rf_addr_d = rx_p_data[ADDR_WIDTH-1:0];
        state_d   = ST_WR_DATA;
      end
      ST_WR_DATA: if (rx_d_vld) begin
        rf_wr_data_d = rx_p_data;
        rf_wr_en_d   = 1'b1;
        state_d      = ST_IDLE;
      end
      ST_RD_ADDR: if (rx_d_vld) begin
        rf_addr_d  = rx_p_data[ADDR_WIDTH-1:0];
        rf_rd_en_d = 1'b1;
        state_d    = ST_RD_WAIT;
      end
      ST_RD_WAIT: if (rf_rd_data_vld) begin
        res_d   = {{DATA_WIDTH{1'b0}}, rf_rd_data};
        state_d = ST_TX_RD;
      end
      ST_ALU_A: if (rx_d_vld) begin
        rf_addr_d    = ADDR_WIDTH'(OPA_ADDR);
        rf_wr_data_d = rx_p_data;
        rf_wr_en_d   = 1'b1;
        state_d      = ST_ALU_B;
      end
      ST_ALU_B: if (rx_d_vld) begin
        rf_addr_d    = ADDR_WIDTH'(OPB_ADDR);
        rf_wr_data_d = rx_p_data;
        rf_wr_en_d   = 1'b1;
        state_d      = ST_ALU_FUN;
      end
      ST_ALU_FUN: if (rx_d_vld) begin
        alu_fun_d = rx_p_data[FUN_WIDTH-1:0];
        state_d   = ST_ALU_WAIT;
      end
      ST_ALU_WAIT: if (alu_out_vld) begin
        res_d   = alu_out;
        state_d = ST_TX_LSB;
      end
      // A TX state is left once its byte shows up on the strobe.
      ST_TX_RD:  if (tx_d_vld) state_d = ST_IDLE;
      ST_TX_LSB: if (tx_d_vld) state_d = ST_TX_MSB;
      ST_TX_MSB: if (tx_d_vld) state_d = ST_IDLE;
      ST_TX_ERR: if (tx_d_vld) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    // Outputs follow the state being entered so they line up with it.
    alu_en_d   = (state_d == ST_ALU_WAIT);
    clk_g_en_d = (state_d == ST_ALU_FUN) || (state_d == ST_ALU_WAIT);

    // The push is attempted on the edge that enters a TX state, which gives a
    // one-cycle result-to-strobe latency; a held state retries until pushed.
    case (state_d)
      ST_TX_MSB: push_byte = res_d[2*DATA_WIDTH-1:DATA_WIDTH];
      ST_TX_ERR: push_byte = DATA_WIDTH'(ERR_RSP);
      default:   push_byte = res_d[DATA_WIDTH-1:0];
    endcase
    push_req = is_tx_state(state_d) && !((state_d == state_q) && tx_d_vld);
  end

  // State and output registers; reset aborts any command in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      rf_wr_en_q   <= 1'b0;
      rf_rd_en_q   <= 1'b0;
      rf_addr_q    <= '0;
      rf_wr_data_q <= '0;
      alu_en_q     <= 1'b0;
      alu_fun_q    <= '0;
      clk_g_en_q   <= 1'b0;
      res_q        <= '0;
    end else begin
      state_q      <= state_d;
      rf_wr_en_q   <= rf_wr_en_d;
      rf_rd_en_q   <= rf_rd_en_d;
      rf_addr_q    <= rf_addr_d;
      rf_wr_data_q <= rf_wr_data_d;
      alu_en_q     <= alu_en_d;
      alu_fun_q    <= alu_fun_d;
      clk_g_en_q   <= clk_g_en_d;
      res_q        <= res_d;
    end
  end

  sys_ctrl_tx_push #(.DATA_WIDTH(DATA_WIDTH)) u_tx_push (
    .clk         (clk),
    .rst         (rst),
    .req_i       (push_req),
    .data_i      (push_byte),
    .fifo_full_i (fifo_full),
    .tx_d_vld_o  (tx_d_vld),
    .tx_p_data_o (tx_p_data)
  );

  assign rf_wr_en   = rf_wr_en_q;
  assign rf_rd_en   = rf_rd_en_q;
  assign rf_addr    = rf_addr_q;
  assign rf_wr_data = rf_wr_data_q;
  assign alu_en     = alu_en_q;
  assign alu_fun    = alu_fun_q;
  assign clk_g_en   = clk_g_en_q;

endmodule

// File: tb/tb_sys_ctrl.sv
// tb_sys_ctrl: directed and randomized command traffic for sys_ctrl. The bench
// plays register file, ALU and TX FIFO, and predicts RF strobes and TX bytes
// from the command rules.
module tb_sys_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_p_data;
  logic        rx_d_vld;
  logic [7:0]  rf_rd_data;
  logic        rf_rd_data_vld;
  logic [15:0] alu_out;
  logic        alu_out_vld;
  logic        fifo_full;
  logic        rf_wr_en, rf_rd_en, alu_en, clk_g_en, tx_d_vld;
  logic [3:0]  rf_addr, alu_fun;
  logic [7:0]  rf_wr_data, tx_p_data;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_wr = 0, exp_rd = 0;
  int wr_seen = 0, rd_seen = 0, both_seen = 0, tx_seen = 0, tx_extra = 0;
  bit full_mode = 1'b0;
  logic full_at_edge = 1'b0;
  logic [7:0] rf_model [16];
  logic [7:0] exp_tx_q [$];

  sys_ctrl dut (
    .clk(clk), .rst(rst), .rx_p_data(rx_p_data), .rx_d_vld(rx_d_vld),
    .rf_rd_data(rf_rd_data), .rf_rd_data_vld(rf_rd_data_vld),
    .alu_out(alu_out), .alu_out_vld(alu_out_vld), .fifo_full(fifo_full),
    .rf_wr_en(rf_wr_en), .rf_rd_en(rf_rd_en), .rf_addr(rf_addr),
    .rf_wr_data(rf_wr_data), .alu_en(alu_en), .alu_fun(alu_fun),
    .clk_g_en(clk_g_en), .tx_p_data(tx_p_data), .tx_d_vld(tx_d_vld)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Behavioural ALU the bench answers with.
  function automatic logic [15:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f);
    case (f)
      4'd0:    return 16'(a) + 16'(b);
      4'd1:    return 16'(a) - 16'(b);
      4'd2:    return 16'(a) * 16'(b);
      4'd3:    return {a, b};
      default: return {8'h00, a ^ b};
    endcase
  endfunction

  // FIFO side: the DUT sampled fifo_full at the edge that produced a push.
  always @(posedge clk) full_at_edge <= fifo_full;

  // Scoreboard: every strobe is counted, every TX byte is matched in order.
  always @(negedge clk) begin
    if (rf_wr_en) wr_seen++;
    if (rf_rd_en) rd_seen++;
    if (rf_wr_en && rf_rd_en) both_seen++;
    if (tx_d_vld) begin
      tx_seen++;
      check("tx_while_full", 32'(full_at_edge), 0);
      if (exp_tx_q.size() == 0) tx_extra++;
      else check("tx_byte", 32'(tx_p_data), 32'(exp_tx_q.pop_front()));
    end
  end

  // Random back-pressure while full_mode is on.
  initial forever begin
    @(negedge clk);
    if (full_mode) fifo_full = ($urandom_range(0, 2) == 0);
  end

  task automatic send_byte(input logic [7:0] b);
    rx_p_data = b;
    rx_d_vld  = 1'b1;
    @(negedge clk);
    rx_d_vld  = 1'b0;
  endtask

  task automatic gap();
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic check_wr(input logic [3:0] a, input logic [7:0] d);
    check("wr_en", 32'(rf_wr_en), 1);
    check("wr_no_rd", 32'(rf_rd_en), 0);
    check("wr_addr", 32'(rf_addr), 32'(a));
    check("wr_data", 32'(rf_wr_data), 32'(d));
    exp_wr++;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_tx_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("tx_drain_left", exp_tx_q.size(), 0);
    exp_tx_q.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic do_wr(input logic [7:0] a, input logic [7:0] d);
    send_byte(8'hAA); gap();
    send_byte(a);     gap();
    send_byte(d);
    check_wr(a[3:0], d);
    rf_model[a[3:0]] = d;
  endtask

  task automatic do_rd(input logic [7:0] a, input int delay);
    send_byte(8'hBB); gap();
    send_byte(a);
    check("rd_en", 32'(rf_rd_en), 1);
    check("rd_no_wr", 32'(rf_wr_en), 0);
    check("rd_addr", 32'(rf_addr), 32'(a[3:0]));
    exp_rd++;
    exp_tx_q.push_back(rf_model[a[3:0]]);
    for (int i = 0; i < delay; i++) begin
      if (i == 0 && delay > 1) begin rx_p_data = 8'hAA; rx_d_vld = 1'b1; end
      @(negedge clk);
      rx_d_vld = 1'b0;
    end
    rf_rd_data     = rf_model[a[3:0]];
    rf_rd_data_vld = 1'b1;
    @(negedge clk);
    rf_rd_data_vld = 1'b0;
    if (!full_mode) check("rd_tx_latency", 32'(tx_d_vld), 1);
    drain();
  endtask

  task automatic do_alu(input bit with_ops, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] fb, input int delay, input int hold_full);
    logic [15:0] res;
    if (with_ops) begin
      send_byte(8'hCC);
      check("cg_off_in_alu_a", 32'(clk_g_en), 0);
      gap();
      send_byte(a); check_wr(4'd0, a); rf_model[0] = a; gap();
      send_byte(b); check_wr(4'd1, b); rf_model[1] = b; gap();
    end else begin
      send_byte(8'hDD);
      check("cg_on_after_dd", 32'(clk_g_en), 1);
      gap();
    end
    send_byte(fb);
    check("alu_en", 32'(alu_en), 1);
    check("alu_fun", 32'(alu_fun), 32'(fb[3:0]));
    check("alu_cg", 32'(clk_g_en), 1);
    res = alu_ref(rf_model[0], rf_model[1], fb[3:0]);
    exp_tx_q.push_back(res[7:0]);
    exp_tx_q.push_back(res[15:8]);
    for (int i = 0; i < delay; i++) begin
      if (i == 0 && delay > 1) begin rx_p_data = 8'hAA; rx_d_vld = 1'b1; end
      @(negedge clk);
      rx_d_vld = 1'b0;
    end
    if (hold_full > 0) fifo_full = 1'b1;
    alu_out     = res;
    alu_out_vld = 1'b1;
    @(negedge clk);
    alu_out_vld = 1'b0;
    check("alu_en_drop", 32'(alu_en), 0);
    check("cg_off_in_tx", 32'(clk_g_en), 0);
    if (hold_full > 0) begin
      for (int i = 0; i < hold_full; i++) begin
        check("no_push_while_full", 32'(tx_d_vld), 0);
        @(negedge clk);
      end
      fifo_full = 1'b0;
    end else if (!full_mode) begin
      check("alu_tx_latency", 32'(tx_d_vld), 1);
    end
    drain();
  endtask

  task automatic do_junk(input logic [7:0] b);
    send_byte(b);
`ifdef SYS_CTRL_ERR_RSP_EN
    exp_tx_q.push_back(8'hEE);
`endif
    drain();
  endtask

  function automatic logic [31:0] all_outputs();
    return 32'({rf_wr_en, rf_rd_en, rf_addr, rf_wr_data, alu_en, alu_fun, clk_g_en, tx_p_data, tx_d_vld});
  endfunction

  initial begin
    logic [7:0] jb;
    int tx_before;
    for (int i = 0; i < 16; i++) rf_model[i] = 8'h00;
    rst = 1'b1; rx_p_data = '0; rx_d_vld = 1'b0; rf_rd_data = '0; rf_rd_data_vld = 1'b0;
    alu_out = '0; alu_out_vld = 1'b0; fifo_full = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", all_outputs(), 0);
    rst = 1'b0;
    @(negedge clk);

    // Directed scenarios.
    do_wr(8'h05, 8'h3C);
    do_rd(8'h05, 1);
    do_alu(1'b1, 8'h10, 8'h20, 8'h00, 2, 0);
    do_alu(1'b0, 8'h00, 8'h00, 8'h02, 1, 5);

    // Reset while waiting for the ALU.
    send_byte(8'hCC);
    send_byte(8'h11); check_wr(4'd0, 8'h11); rf_model[0] = 8'h11;
    send_byte(8'h22); check_wr(4'd1, 8'h22); rf_model[1] = 8'h22;
    send_byte(8'h01);
    check("pre_reset_alu_en", 32'(alu_en), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_reset_outputs", all_outputs(), 0);
    tx_before = tx_seen;
    repeat (2) @(negedge clk);
    alu_out = 16'h1234; alu_out_vld = 1'b1;
    @(negedge clk);
    alu_out_vld = 1'b0;
    repeat (4) @(negedge clk);
    check("no_push_after_reset", tx_seen, tx_before);

    do_junk(8'h55);

    // Randomized traffic with optional back-pressure.
    for (int t = 0; t < 40; t++) begin
      full_mode = 1'($urandom_range(0, 1));
      if (!full_mode) fifo_full = 1'b0;
      case ($urandom_range(0, 4))
        0: do_wr(8'($urandom), 8'($urandom));
        1: do_rd(8'($urandom), $urandom_range(0, 4));
        2: do_alu(1'b1, 8'($urandom), 8'($urandom), 8'($urandom), $urandom_range(0, 4), 0);
        3: do_alu(1'b0, 8'h00, 8'h00, 8'($urandom), $urandom_range(0, 4), 0);
        default: begin
          jb = 8'($urandom);
          while (jb == 8'hAA || jb == 8'hBB || jb == 8'hCC || jb == 8'hDD) jb = 8'($urandom);
          do_junk(jb);
        end
      endcase
    end
    full_mode = 1'b0;
    fifo_full = 1'b0;
    repeat (4) @(negedge clk);

    check("wr_strobe_count", wr_seen, exp_wr);
    check("rd_strobe_count", rd_seen, exp_rd);
    check("wr_rd_overlap", both_seen, 0);
    check("tx_unexpected", tx_extra, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1);
  end

endmodule
